capture_mem_reader: RTL and testbench
=====================================

Name: capture_mem_reader

Overview:
Read-side controller for the 32768x36 capture SRAM. It is the reader counterpart of the write path into the SRAM wrapper.
- On a start pulse it issues a burst of single-port reads: CEB low, WEB high, incrementing A.
- It absorbs the SRAM's fixed 1-cycle read latency and streams the words out on a valid/ready interface toward the packet controller.
- It sits between the SRAM wrapper and the packet/upload logic.

Parameters:
ADDR_WIDTH, 15, SRAM address width; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 36, SRAM word width.
LEN_WIDTH, ADDR_WIDTH+1, width of the burst-length field; holds the full depth 32768.

Ports:
CLK  input  1  single clock; SRAM and all logic run on it.
RST  input  1  synchronous active-high reset.
start  input  1  one-cycle pulse; ignored while busy=1.
start_addr  input  ADDR_WIDTH  first SRAM address, sampled on start.
rd_len  input  LEN_WIDTH  number of words to read, sampled on start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when the last word has left on out_*.
CEB  output  1  SRAM chip enable, active low.
WEB  output  1  SRAM write enable, active low; tied 1 (read only).
A  output  ADDR_WIDTH  SRAM address.
Q  input  DATA_WIDTH  SRAM read data, valid the cycle after CEB=0.
out_data  output  DATA_WIDTH  stream data.
out_valid  output  1  stream valid.
out_ready  input  1  stream ready.
out_last  output  1  only with CAPTURE_RD_LAST_EN; marks the final word.

Behaviour:
Reset values:
- CEB=1, WEB=1, A=0, busy=0, done=0, out_valid=0, out_data=0.
- State IDLE; FIFO empty; counters 0.
- RST mid-burst aborts immediately: reads stop and the FIFO is flushed. No done pulse is produced.

Registered outputs: CEB, A, busy and done are registered.

FSM states:
- IDLE: on start with rd_len != 0, latch addr=start_addr, issue_cnt=rd_len, out_cnt=rd_len, then go to READ. On start with rd_len=0, pulse done the next cycle and stay in IDLE (busy stays 0).
- READ: issue one read per cycle while credit allows. Each issue drives CEB=0 and A=addr for one cycle, then addr+1 and issue_cnt-1. When issue_cnt reaches 0, go to DRAIN.
- DRAIN: wait until out_cnt=0, i.e. the last out_valid&&out_ready handshake. Then pulse done for 1 cycle and return to IDLE.

Credit and buffering:
- Output FIFO of 2 entries.
- inflight=1 in the cycle after an issue; Q is pushed into the FIFO in that cycle.
- Issue is allowed iff fifo_count + inflight - pop < 2, where pop = out_valid && out_ready in the current cycle.
- This keeps 1 word/cycle throughput when out_ready stays high and guarantees no FIFO overflow.

Stream rules:
- out_valid = FIFO non-empty; out_data = FIFO head.
- Once out_valid is asserted, out_data must hold stable until the handshake.
- Push and pop in the same cycle are both legal.

Timing and boundaries:
- Latency from start to first out_valid is 3 cycles (start → issue at +1 → Q push at +2 → out_valid at +3).
- Address wraps modulo 2**ADDR_WIDTH: 32767 → 0.
- start while busy is dropped with no effect.

Optional Feature:
CAPTURE_RD_LAST_EN:
- Defined: out_last is added; it is high together with out_valid on the word where out_cnt=1, and follows the same hold rules as out_data.
- Undefined: the port and its logic are absent; the consumer uses done instead.

Decomposition:
- Package capture_mem_pkg holds: the default ADDR_WIDTH/DATA_WIDTH constants, the FSM state enum (IDLE, READ, DRAIN), and the SRAM read latency constant (1).
- One sub-module: capture_rd_fifo2, a 2-entry FIFO with push/pop/count ports, reusable on the write side.

Test Plan:
- Preload mem[i]=i; start_addr=0x0010, rd_len=4, out_ready=1 → words 0x10..0x13 on consecutive cycles, first out_valid 3 cycles after start, done 1 cycle after the last handshake, exactly 4 CEB-low cycles.
- start_addr=0x7FFE, rd_len=4 → A sequence 7FFE, 7FFF, 0000, 0001, data in the same order.
- rd_len=8, out_ready toggling 1,0,0,1,... → no word lost or duplicated, out_data stable while stalled, FIFO never holds more than 2 words, CEB gated off during stalls.
- rd_len=0 → done pulses once, busy stays 0, CEB never low; a second start during a busy burst is ignored.
- RST asserted mid-burst after 3 words → all outputs return to reset values the next cycle, no done; a new start afterwards reads correctly.
- With CAPTURE_RD_LAST_EN, rd_len=5 → out_last high only on the 5th handshake.

Source files
------------

// File: rtl/capture_mem_pkg.sv
// Shared definitions for the capture SRAM read path: default geometry,
// reader FSM states and the SRAM read latency.
package capture_mem_pkg;

    localparam int CAP_ADDR_WIDTH  = 15;
    localparam int CAP_DATA_WIDTH  = 36;
    localparam int SRAM_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/capture_mem_reader_if.sv
// Valid/ready stream from the capture SRAM reader toward the packet logic.
// Optional macro CAPTURE_RD_LAST_EN adds out_last, which marks the final word.
interface capture_mem_reader_if
    import capture_mem_pkg::*;
#(
    parameter int DATA_WIDTH = CAP_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
`ifdef CAPTURE_RD_LAST_EN
    logic                  out_last;
`endif

    modport master (
        output out_data,
        output out_valid,
`ifdef CAPTURE_RD_LAST_EN
        output out_last,
`endif
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
`ifdef CAPTURE_RD_LAST_EN
        input  out_last,
`endif
        output out_ready
    );

endinterface

// File: rtl/capture_rd_fifo2.sv
// Two-entry FIFO. entry0 is always the head, so the head word stays put until
// it is popped. A push into a full FIFO is taken only when a pop happens in the
// same cycle.
module capture_rd_fifo2
    import capture_mem_pkg::*;
#(
    parameter int WIDTH = CAP_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);
    assign dout    = entry0;

    // Shift-register storage: pops move entry1 forward, pushes fill the first free slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= din;
                    end else begin
                        entry1 <= din;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end else begin
                        entry0 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/capture_mem_reader.sv
// Burst reader for the capture SRAM. On start it issues single-port reads
// (CEB low, WEB high, incrementing A), absorbs the SRAM read latency and
// streams the words through a 2-entry FIFO onto a valid/ready interface.
// Optional macro CAPTURE_RD_LAST_EN drives out_last on the final word.
//
// Credit: inflight marks a word sitting on Q that the FIFO has not taken yet.
// A read is issued only while fifo_count + inflight - pop < 2. If the FIFO is
// full when a word lands, the word stays on Q until there is room, because the
// SRAM macro keeps Q unchanged while CEB is high and the credit rule blocks
// every new read in that situation. This keeps one word per cycle when
// out_ready is held high and never overruns the FIFO.
module capture_mem_reader
    import capture_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = CAP_ADDR_WIDTH,
    parameter int DATA_WIDTH = CAP_DATA_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  rd_len,
    output logic                  busy,
    output logic                  done,
    output logic                  CEB,
    output logic                  WEB,
    output logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] Q,
    capture_mem_reader_if.master  stream
);

    rd_state_t                  state;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [LEN_WIDTH-1:0]       issue_cnt;
    logic [LEN_WIDTH-1:0]       out_cnt;
    logic [SRAM_RD_LATENCY-1:0] rd_pipe;
    logic                       q_hold;
    logic                       inflight;
    logic                       pop;
    logic                       push;
    logic                       can_issue;
    logic [1:0]                 fifo_count;
    logic [2:0]                 occupancy;

    assign WEB       = 1'b1;
    assign pop       = stream.out_valid && stream.out_ready;
    assign inflight  = rd_pipe[SRAM_RD_LATENCY-1] || q_hold;
    assign push      = inflight && ((fifo_count != 2'd2) || pop);
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign can_issue = (occupancy < 3'd2);

    assign stream.out_valid = (fifo_count != 2'd0);

`ifdef CAPTURE_RD_LAST_EN
    assign stream.out_last = stream.out_valid && (out_cnt == LEN_WIDTH'(1));
`endif

    capture_rd_fifo2 #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .din   (Q),
        .dout  (stream.out_data),
        .count (fifo_count)
    );

    // Track which cycle's Q carries a fresh word, and hold a landed word until the FIFO takes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_pipe <= '0;
            q_hold  <= 1'b0;
        end else begin
            rd_pipe <= SRAM_RD_LATENCY'({rd_pipe, ~CEB});
            q_hold  <= inflight && !push;
        end
    end

    // Reader FSM: accept start, issue reads under credit, then wait for the last handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            CEB       <= 1'b1;
            A         <= '0;
            addr      <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pop) begin
                out_cnt <= out_cnt - 1'b1;
            end
            unique case (state)
                IDLE: begin
                    CEB <= 1'b1;
                    if (start) begin
                        if (rd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            CEB       <= 1'b0;
                            A         <= start_addr;
                            addr      <= start_addr + 1'b1;
                            issue_cnt <= rd_len - 1'b1;
                            out_cnt   <= rd_len;
                            busy      <= 1'b1;
                            state     <= (rd_len == LEN_WIDTH'(1)) ? DRAIN : READ;
                        end
                    end
                end
                READ: begin
                    if (can_issue) begin
                        CEB       <= 1'b0;
                        A         <= addr;
                        addr      <= addr + 1'b1;
                        issue_cnt <= issue_cnt - 1'b1;
                        if (issue_cnt == LEN_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end else begin
                        CEB <= 1'b1;
                    end
                end
                DRAIN: begin
                    CEB <= 1'b1;
                    if (pop && (out_cnt == LEN_WIDTH'(1))) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    CEB   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_mem_reader.sv
// Self-checking bench for capture_mem_reader with a behavioural SRAM
// (mem[i] = i, Q holds while CEB is high). Build with CAPTURE_RD_LAST_EN
// defined to also check out_last.
module tb_capture_mem_reader;

    localparam int AW = 15;
    localparam int DW = 36;
    localparam int LW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [LW-1:0] rd_len;
    logic          busy;
    logic          done;
    logic          CEB;
    logic          WEB;
    logic [AW-1:0] A;
    logic [DW-1:0] Q;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fails  = 0;

    capture_mem_reader_if stream_if ();

    capture_mem_reader dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .start_addr (start_addr),
        .rd_len     (rd_len),
        .busy       (busy),
        .done       (done),
        .CEB        (CEB),
        .WEB        (WEB),
        .A          (A),
        .Q          (Q),
        .stream     (stream_if)
    );

    always #5 CLK = ~CLK;

    // Single-port SRAM read model with one cycle of latency and held output.
    always @(posedge CLK) begin
        if (!CEB && WEB) begin
            Q <= mem[A];
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [7:0]    ready_mask;
        int            dup_cycle;
        logic [AW-1:0] dup_addr;
        logic [DW-1:0] first_word;
        logic [DW-1:0] last_word;
        int            latency;
    } burst_vec_t;

    burst_vec_t vecs [0:5];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic r);
        start               = s;
        start_addr          = a;
        rd_len              = l;
        stream_if.out_ready = r;
    endtask

    task automatic runBurst(input burst_vec_t v);
        int            first_valid = -1;
        int            done_cycle  = -1;
        int            last_hs     = -100;
        int            n_words     = 0;
        int            n_issues    = 0;
        logic          prev_pending = 1'b0;
        logic [DW-1:0] prev_data    = '0;
        logic          rdy;
        logic          hs;
        logic [AW-1:0] ea;
        logic [AW-1:0] wa;
        @(negedge CLK);
        applyStimulus(1'b1, v.addr, v.len, v.ready_mask[0]);
        for (int k = 1; k <= 200; k++) begin
            @(negedge CLK);
            rdy = v.ready_mask[k % 8];
            if (k == v.dup_cycle) begin
                applyStimulus(1'b1, v.dup_addr, 16'd3, rdy);
            end else begin
                applyStimulus(1'b0, '0, '0, rdy);
            end
            if (done_cycle >= 0) begin
                checkOutput("done_single_pulse", done, 1'b0);
                checkOutput("busy_after_done", busy, 1'b0);
                break;
            end
            if (!CEB) begin
                ea = v.addr + AW'(n_issues);
                checkOutput("issue_addr", A, ea);
                n_issues++;
            end
            if (stream_if.out_valid && first_valid < 0) begin
                first_valid = k;
            end
            if (prev_pending) begin
                checkOutput("hold_valid", stream_if.out_valid, 1'b1);
                checkOutput("hold_data", stream_if.out_data, prev_data);
            end
            hs = stream_if.out_valid && rdy;
            if (hs) begin
                wa = v.addr + AW'(n_words);
                checkOutput("stream_data", stream_if.out_data, DW'(wa));
                if (n_words == 0) begin
                    checkOutput("first_word", stream_if.out_data, v.first_word);
                end
                if (n_words == int'(v.len) - 1) begin
                    checkOutput("last_word", stream_if.out_data, v.last_word);
                end
`ifdef CAPTURE_RD_LAST_EN
                checkOutput("out_last", stream_if.out_last, (n_words == int'(v.len) - 1));
`endif
                n_words++;
                last_hs = k;
            end
            prev_pending = stream_if.out_valid && !rdy;
            prev_data    = stream_if.out_data;
            if (done) begin
                done_cycle = k;
                checkOutput("busy_at_done", busy, 1'b0);
            end else begin
                checkOutput("busy_running", busy, 1'b1);
            end
        end
        checkOutput("done_seen", (done_cycle >= 0), 1'b1);
        checkOutput("word_count", n_words, v.len);
        checkOutput("ceb_low_count", n_issues, v.len);
        checkOutput("first_latency", first_valid, v.latency);
        checkOutput("done_after_last", done_cycle - last_hs, 1);
    endtask

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected the bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        burst_vec_t post;
        int         hs_count;
        logic       saw_done;
        logic       saw_valid;
        logic       saw_ceb;

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = DW'(i);
        end
        Q = '0;

        //        addr      len    ready        dup  dup_addr   first       last        lat
        vecs[0] = '{15'h0010, 16'd4, 8'hFF,       -1, 15'h0000, 36'h00010, 36'h00013, 3};
        vecs[1] = '{15'h7FFE, 16'd4, 8'hFF,       -1, 15'h0000, 36'h07FFE, 36'h00001, 3};
        vecs[2] = '{15'h0100, 16'd8, 8'b10011001, -1, 15'h0000, 36'h00100, 36'h00107, 3};
        vecs[3] = '{15'h0200, 16'd6, 8'hFF,        2, 15'h0555, 36'h00200, 36'h00205, 3};
        vecs[4] = '{15'h0300, 16'd5, 8'b11011011, -1, 15'h0000, 36'h00300, 36'h00304, 3};
        vecs[5] = '{15'h7FFF, 16'd2, 8'b01010101, -1, 15'h0000, 36'h07FFF, 36'h00000, 3};
        post    = '{15'h0020, 16'd2, 8'hFF,       -1, 15'h0000, 36'h00020, 36'h00021, 3};

        // Reset state.
        RST = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b1);
        repeat (3) @(negedge CLK);
        checkOutput("rst_CEB", CEB, 1'b1);
        checkOutput("rst_WEB", WEB, 1'b1);
        checkOutput("rst_A", A, 15'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_valid", stream_if.out_valid, 1'b0);
        checkOutput("rst_data", stream_if.out_data, 36'h0);
        RST = 1'b0;

        // Directed burst table.
        for (int i = 0; i < 6; i++) begin
            $display("[TB] burst %0d addr=0x%0h len=%0d", i, vecs[i].addr, vecs[i].len);
            runBurst(vecs[i]);
        end

        // Zero-length start: one done pulse, never busy, no reads.
        @(negedge CLK);
        applyStimulus(1'b1, 15'h0123, 16'd0, 1'b1);
        @(negedge CLK);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("len0_done", done, 1'b1);
        checkOutput("len0_busy", busy, 1'b0);
        checkOutput("len0_CEB", CEB, 1'b1);
        @(negedge CLK);
        checkOutput("len0_done_drop", done, 1'b0);
        checkOutput("len0_busy_idle", busy, 1'b0);
        checkOutput("len0_CEB_idle", CEB, 1'b1);
        checkOutput("len0_no_valid", stream_if.out_valid, 1'b0);

        // Reset mid-burst after three words have left.
        @(negedge CLK);
        applyStimulus(1'b1, 15'h0040, 16'd10, 1'b1);
        hs_count = 0;
        for (int k = 1; k <= 30 && hs_count < 3; k++) begin
            @(negedge CLK);
            applyStimulus(1'b0, '0, '0, 1'b1);
            if (stream_if.out_valid) begin
                checkOutput("midrst_data", stream_if.out_data, 36'h40 + 36'(hs_count));
                hs_count++;
            end
        end
        checkOutput("midrst_three_words", hs_count, 3);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checkOutput("midrst_CEB", CEB, 1'b1);
        checkOutput("midrst_A", A, 15'h0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        checkOutput("midrst_valid", stream_if.out_valid, 1'b0);
        checkOutput("midrst_data_clr", stream_if.out_data, 36'h0);
        saw_done  = 1'b0;
        saw_valid = 1'b0;
        saw_ceb   = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            saw_done  = saw_done | done;
            saw_valid = saw_valid | stream_if.out_valid;
            saw_ceb   = saw_ceb | !CEB;
        end
        checkOutput("midrst_no_done", saw_done, 1'b0);
        checkOutput("midrst_no_valid", saw_valid, 1'b0);
        checkOutput("midrst_no_reads", saw_ceb, 1'b0);

        // A fresh burst after the abort reads correctly.
        $display("[TB] burst after reset addr=0x%0h len=%0d", post.addr, post.len);
        runBurst(post);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
